// File: rtl/vend_dispense_ctrl_if.sv
// Handshake bundle between the dispense sequencer, the credit FSM and the motor/hopper drivers.
// Latency: none (wires only).
// Backpressure: none here; the motor and hopper handshakes are request/done levels.
//
// Ports (grouped as signals):
//   credit/vend_req/cancel     credit FSM -> sequencer
//   credit_clr/deny            sequencer -> credit FSM
//   motor_go/motor_done        product motor request/completion
//   hop_req/hop_sel/hop_ack    hopper coin request, denomination, ejection ack
//   bal/prod_cnt/busy/err      status
// The master modport is the sequencer; slave is the surrounding hardware.
interface vend_dispense_ctrl_if #(
   parameter int CREDIT_W = 4
);
   logic [CREDIT_W-1:0] credit;
   logic                vend_req;
   logic                cancel;
   logic                credit_clr;
   logic                deny;
   logic                motor_go;
   logic                motor_done;
   logic                hop_req;
   logic                hop_sel;
   logic                hop_ack;
   logic [CREDIT_W-1:0] bal;
   logic [7:0]          prod_cnt;
   logic                busy;
   logic                err;

   modport master (
      input  credit, vend_req, cancel, motor_done, hop_ack,
      output credit_clr, deny, motor_go, hop_req, hop_sel, bal, prod_cnt, busy, err
   );

   modport slave (
      output credit, vend_req, cancel, motor_done, hop_ack,
      input  credit_clr, deny, motor_go, hop_req, hop_sel, bal, prod_cnt, busy, err
   );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// Vend/refund sequencer: latches credit, runs the motor, pays change greedily (5s then 1s).
// Latency: every output registered; reaction one cycle after the sampling edge.
// Backpressure: waits indefinitely on motor_done/hop_ack unless VEND_WDOG_EN arms the watchdog.
//
// Ports: clk, rst_n (async active-low), bus (vend_dispense_ctrl_if.master).
// Parameters: CREDIT_W credit width, PRICE product price, TMO_CYC watchdog limit.
// Optional feature macro: VEND_WDOG_EN enables the watchdog and the FAULT state;
// without it err is constant 0 and FAULT is unreachable.
module vend_dispense_ctrl #(
   parameter int CREDIT_W = 4,
   parameter int PRICE    = 10,
   parameter int TMO_CYC  = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   vend_dispense_ctrl_if.master bus
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_VEND   = 3'd1;
   localparam logic [2:0] ST_CHANGE = 3'd2;
   localparam logic [2:0] ST_GAP    = 3'd3;
   localparam logic [2:0] ST_FAULT  = 3'd4;

   localparam logic [CREDIT_W-1:0] L_PRICE = CREDIT_W'(PRICE);

   // Elaboration-time parameter sanity checks.
   if (PRICE < 1 || PRICE > (2**CREDIT_W) - 1) begin : g_price_chk
      $error("vend_dispense_ctrl: PRICE out of range for CREDIT_W");
   end
   if (TMO_CYC < 1) begin : g_tmo_chk
      $error("vend_dispense_ctrl: TMO_CYC must be >= 1");
   end

   logic [2:0]          r_state;
   logic [CREDIT_W-1:0] r_bal;
   logic [7:0]          r_prod_cnt;
   logic                r_credit_clr;
   logic                r_deny;
   logic                r_motor_go;
   logic                r_hop_req;
   logic                r_hop_sel;
   logic                r_busy;
   logic                r_err;

   logic [2:0]          w_state_nxt;
   logic [CREDIT_W-1:0] w_bal_nxt;
   logic [7:0]          w_prod_nxt;
   logic                w_clr_nxt;
   logic                w_deny_nxt;
   logic                w_tmo;
   logic                w_err_nxt;

   always_comb begin
      w_state_nxt = r_state;
      w_bal_nxt   = r_bal;
      w_prod_nxt  = r_prod_cnt;
      w_clr_nxt   = 1'b0;
      w_deny_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // cancel outranks vend_req; cancel with zero credit swallows the vend too
            if (bus.cancel) begin
               if (bus.credit != '0) begin
                  w_bal_nxt   = bus.credit;
                  w_clr_nxt   = 1'b1;
                  w_state_nxt = ST_CHANGE;
               end
            end else if (bus.vend_req) begin
               if (bus.credit >= L_PRICE) begin
                  w_bal_nxt   = bus.credit - L_PRICE;
                  w_clr_nxt   = 1'b1;
                  w_state_nxt = ST_VEND;
               end else begin
                  w_deny_nxt  = 1'b1;
               end
            end
         end
         ST_VEND: begin
            if (bus.motor_done) begin
               w_prod_nxt  = r_prod_cnt + 8'd1;
               w_state_nxt = (r_bal != '0) ? ST_CHANGE : ST_IDLE;
            end else if (w_tmo) begin
               w_state_nxt = ST_FAULT;
            end
         end
         ST_CHANGE: begin
            if (bus.hop_ack) begin
               if (int'(r_bal) >= 5) begin
                  w_bal_nxt = r_bal - CREDIT_W'(5);
               end else if (r_bal != '0) begin
                  w_bal_nxt = r_bal - CREDIT_W'(1);
               end
               w_state_nxt = ST_GAP;
            end else if (w_tmo) begin
               w_state_nxt = ST_FAULT;
            end
         end
         ST_GAP: begin
            w_state_nxt = (r_bal != '0) ? ST_CHANGE : ST_IDLE;
         end
         ST_FAULT: begin
            w_state_nxt = ST_FAULT;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

`ifdef VEND_WDOG_EN
   localparam int WDOG_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

   logic [WDOG_W-1:0] r_wdog;

   // Restarts on every state change, so each VEND and each CHANGE visit
   // (including GAP->CHANGE) gets a fresh TMO_CYC budget.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wdog <= '0;
      end else if (w_state_nxt != r_state) begin
         r_wdog <= '0;
      end else if (r_state == ST_VEND || r_state == ST_CHANGE) begin
         r_wdog <= r_wdog + WDOG_W'(1);
      end
   end

   assign w_tmo     = (r_wdog == WDOG_W'(TMO_CYC - 1));
   assign w_err_nxt = (w_state_nxt == ST_FAULT);
`else
   assign w_tmo     = 1'b0;
   assign w_err_nxt = 1'b0;
`endif

   // Outputs are derived from next-state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_bal        <= '0;
         r_prod_cnt   <= '0;
         r_credit_clr <= 1'b0;
         r_deny       <= 1'b0;
         r_motor_go   <= 1'b0;
         r_hop_req    <= 1'b0;
         r_hop_sel    <= 1'b0;
         r_busy       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_bal        <= w_bal_nxt;
         r_prod_cnt   <= w_prod_nxt;
         r_credit_clr <= w_clr_nxt;
         r_deny       <= w_deny_nxt;
         r_motor_go   <= (w_state_nxt == ST_VEND);
         r_hop_req    <= (w_state_nxt == ST_CHANGE);
         r_hop_sel    <= (w_state_nxt == ST_CHANGE) && (int'(w_bal_nxt) >= 5);
         r_busy       <= (w_state_nxt != ST_IDLE);
         r_err        <= w_err_nxt;
      end
   end

   assign bus.credit_clr = r_credit_clr;
   assign bus.deny       = r_deny;
   assign bus.motor_go   = r_motor_go;
   assign bus.hop_req    = r_hop_req;
   assign bus.hop_sel    = r_hop_sel;
   assign bus.bal        = r_bal;
   assign bus.prod_cnt   = r_prod_cnt;
   assign bus.busy       = r_busy;
   assign bus.err        = r_err;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench for vend_dispense_ctrl (CREDIT_W=4, PRICE=10, TMO_CYC=20).
// Latency: n/a.
// Backpressure: bench plays motor and hopper, acking coins after a random 0-2 cycle delay.
module tb_vend_dispense_ctrl;

   logic clk;
   logic rst_n;

   vend_dispense_ctrl_if #(.CREDIT_W(4)) bus ();

   vend_dispense_ctrl #(
      .CREDIT_W (4),
      .PRICE    (10),
      .TMO_CYC  (20)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int credit;
      bit vend;
      bit cancel;
      int mdly;       // cycles motor_go stays high before motor_done
      bit exp_clr;
      bit exp_deny;
      bit exp_motor;
      int exp_bal;    // change owed right after the request
   } vec_t;

   int         n_cmp;
   int         n_err;
   logic [7:0] exp_prod;
   bit         exp_sel_q[$];   // scoreboard: expected hop_sel per coin
   vec_t       vecs[10];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_coins(input int amt);
      int a;
      a = amt;
      while (a >= 5) begin exp_sel_q.push_back(1'b1); a -= 5; end
      while (a > 0)  begin exp_sel_q.push_back(1'b0); a -= 1; end
   endtask

   // Called at a negedge with the DUT idle.
   task automatic run_txn(input vec_t v);
      int   hi;
      int   budget;
      int   eb;
      logic sel;
      bus.credit   = v.credit[3:0];
      bus.vend_req = v.vend;
      bus.cancel   = v.cancel;
      @(negedge clk);
      bus.vend_req = 1'b0;
      bus.cancel   = 1'b0;
      bus.credit   = '0;
      check("credit_clr", bus.credit_clr, v.exp_clr);
      check("deny", bus.deny, v.exp_deny);
      check("motor_go", bus.motor_go, v.exp_motor);
      check("busy", bus.busy, v.exp_clr);
      check("bal_latched", bus.bal, v.exp_bal);
      push_coins(v.exp_bal);
      eb = v.exp_bal;
      if (v.exp_motor) begin
         hi = 1;
         for (int i = 1; i < v.mdly; i++) begin
            bus.hop_ack = (i == 1);   // stray ack during VEND must be ignored
            @(negedge clk);
            bus.hop_ack = 1'b0;
            if (bus.motor_go) hi++;
            if (i == 1) check("credit_clr_1cyc", bus.credit_clr, 0);
         end
         bus.motor_done = 1'b1;
         @(negedge clk);
         bus.motor_done = 1'b0;
         exp_prod = exp_prod + 8'd1;
         check("motor_hi_cycles", hi, v.mdly);
         check("motor_go_off", bus.motor_go, 0);
         check("prod_cnt", bus.prod_cnt, exp_prod);
         check("bal_after_motor", bus.bal, eb);
      end
      budget = 0;
      while (bus.busy && budget < 200) begin
         if (bus.hop_req) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               budget++;
            end
            sel = bus.hop_sel;
            if (exp_sel_q.size() == 0) begin
               check("extra_coin", 1, 0);
            end else begin
               check("hop_sel", sel, exp_sel_q.pop_front());
            end
            eb = eb - (sel ? 5 : 1);
            bus.hop_ack = 1'b1;
            @(negedge clk);
            bus.hop_ack = 1'b0;
            check("gap_hop_req", bus.hop_req, 0);
            check("bal_dec", bus.bal, eb);
         end else begin
            @(negedge clk);
         end
         budget++;
      end
      if (budget >= 200) check("txn_timeout", 1, 0);
      check("coins_missing", exp_sel_q.size(), 0);
      exp_sel_q.delete();
      check("end_bal", bus.bal, 0);
      check("end_prod", bus.prod_cnt, exp_prod);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      exp_prod = 8'd0;
      vecs[0] = '{13, 1, 0, 5, 1, 0, 1, 3};   // 3 one-unit coins
      vecs[1] = '{15, 1, 0, 2, 1, 0, 1, 5};   // one 5-unit coin
      vecs[2] = '{12, 1, 1, 0, 1, 0, 0, 12};  // cancel beats vend: 5,5,1,1
      vecs[3] = '{ 9, 1, 0, 0, 0, 1, 0, 0};   // short credit -> deny
      vecs[4] = '{10, 1, 0, 3, 1, 0, 1, 0};   // exact price, no change
      vecs[5] = '{ 0, 0, 1, 0, 0, 0, 0, 0};   // cancel with no credit
      vecs[6] = '{ 7, 0, 1, 0, 1, 0, 0, 7};   // refund 5,1,1
      vecs[7] = '{ 0, 1, 0, 0, 0, 1, 0, 0};   // vend with zero credit
      vecs[8] = '{14, 1, 0, 1, 1, 0, 1, 4};   // done next cycle, 4 ones
      vecs[9] = '{ 0, 1, 1, 0, 0, 0, 0, 0};   // cancel at zero swallows vend

      rst_n          = 1'b0;
      bus.credit     = '0;
      bus.vend_req   = 1'b0;
      bus.cancel     = 1'b0;
      bus.motor_done = 1'b0;
      bus.hop_ack    = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_bal", bus.bal, 0);
      check("rst_prod", bus.prod_cnt, 0);
      check("rst_err", bus.err, 0);
      check("rst_hop_req", bus.hop_req, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) run_txn(vecs[i]);

      // Reset in CHANGE with bal=4 takes effect without a clock edge.
      bus.credit = 4'd14; bus.vend_req = 1'b1;
      @(negedge clk);
      bus.vend_req = 1'b0; bus.credit = '0; bus.motor_done = 1'b1;
      @(negedge clk);
      bus.motor_done = 1'b0;
      check("pre_rst_hop_req", bus.hop_req, 1);
      check("pre_rst_bal", bus.bal, 4);
      #2 rst_n = 1'b0;
      #1;
      check("arst_bal", bus.bal, 0);
      check("arst_hop_req", bus.hop_req, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_prod", bus.prod_cnt, 0);
      check("arst_motor_go", bus.motor_go, 0);
      exp_prod = 8'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", bus.busy, 0);

      // Drive prod_cnt to 255, then one more vend wraps it to 0.
      for (int i = 0; i < 255; i++) begin
         bus.credit = 4'd10; bus.vend_req = 1'b1;
         @(negedge clk);
         bus.vend_req = 1'b0; bus.credit = '0; bus.motor_done = 1'b1;
         @(negedge clk);
         bus.motor_done = 1'b0;
      end
      exp_prod = 8'd255;
      check("prod_255", bus.prod_cnt, 255);
      run_txn('{10, 1, 0, 1, 1, 0, 1, 0});
      check("prod_wrap", bus.prod_cnt, 0);

      // Held vend_req with short credit: deny every cycle.
      bus.credit = 4'd5; bus.vend_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("held_deny", bus.deny, 1);
         check("held_no_clr", bus.credit_clr, 0);
      end
      bus.vend_req = 1'b0; bus.credit = '0;
      @(negedge clk);
      check("held_deny_end", bus.deny, 0);
      check("held_busy", bus.busy, 0);

`ifdef VEND_WDOG_EN
      bus.credit = 4'd10; bus.vend_req = 1'b1;
      @(negedge clk);
      bus.vend_req = 1'b0; bus.credit = '0;
      repeat (19) @(negedge clk);
      check("wdog_err_before", bus.err, 0);
      check("wdog_motor_before", bus.motor_go, 1);
      @(negedge clk);
      check("wdog_err", bus.err, 1);
      check("wdog_motor_off", bus.motor_go, 0);
      check("wdog_busy", bus.busy, 1);
      bus.credit = 4'd15; bus.vend_req = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("fault_no_clr", bus.credit_clr, 0);
         check("fault_sticky", bus.err, 1);
      end
      bus.vend_req = 1'b0; bus.credit = '0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("fault_cleared", bus.err, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
